// File: rtl/bus_stim_sequencer_pkg.sv
// Shared types and widths for the programmable bus stimulus sequencer.
package stim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } stim_state_e;

    localparam int STIM_ADDR_W = 6;
    localparam int STIM_HOLD_W = 4;

    // Width of one program-table entry: {en, wr, addr, hold}.
    function automatic int entry_w(int addr_w, int hold_w);
        return 2 + addr_w + hold_w;
    endfunction

endpackage

// File: rtl/bus_stim_sequencer_if.sv
// Stimulus bus between the sequencer (master) and the target port (slave).
interface bus_stim_sequencer_if #(
    parameter int ADDR_W = stim_pkg::STIM_ADDR_W
);

    logic              en;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic              ready;

    modport master (output en, output wr, output addr, input ready);
    modport slave  (input en, input wr, input addr, output ready);

endinterface

// File: rtl/bus_stim_sequencer_prog_ram.sv
// Program table: one synchronous write port, one asynchronous read port.
module stim_prog_ram #(
    parameter int  DEPTH = 8,
    parameter int  WIDTH = 12,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage has no reset; programmed entries must survive rst.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_stim_sequencer.sv
// Replays a programmed table of {en, wr, addr, hold} entries onto the stimulus
// bus, stalling on ready, optionally looping, with abort via stop.
module bus_stim_sequencer import stim_pkg::*; #(
    parameter int  ADDR_W  = STIM_ADDR_W,
    parameter int  DEPTH   = 8,
    parameter int  HOLD_W  = STIM_HOLD_W,
    localparam int IDX_W   = $clog2(DEPTH),
    localparam int LEN_W   = $clog2(DEPTH + 1),
    localparam int ENTRY_W = entry_w(ADDR_W, HOLD_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prog_we,
    input  logic [IDX_W-1:0]     prog_idx,
    input  logic [ENTRY_W-1:0]   prog_data,
    input  logic [LEN_W-1:0]     len,
    input  logic                 loop,
    input  logic                 start,
    input  logic                 stop,
    bus_stim_sequencer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     step_idx
);

    stim_state_e state_q, state_d;

    logic              en_q, en_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]  step_q, step_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              loop_q, loop_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [IDX_W-1:0]   rd_idx;
    logic [ENTRY_W-1:0] rd_data;
    logic               prog_ok;
    logic               start_ok;
    logic               last;

    // The table only changes in IDLE, so the running program is stable.
    assign prog_ok  = prog_we && (state_q == IDLE) && (int'(prog_idx) < DEPTH);
    assign start_ok = start && !stop && (len != '0);
    assign last     = (LEN_W'(step_q) == (len_q - LEN_W'(1)));

    stim_prog_ram #(
        .DEPTH(DEPTH),
        .WIDTH(ENTRY_W)
    ) u_prog_ram (
        .clk  (clk),
        .we   (prog_ok),
        .waddr(prog_idx),
        .wdata(prog_data),
        .raddr(rd_idx),
        .rdata(rd_data)
    );

    // Entry to load on the next completion: 0 on start or wrap, else step+1.
    always_comb begin
        rd_idx = '0;
        if (state_q == RUN && !last) rd_idx = step_q + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: every variable gets its default first so no path infers a latch.
        state_d    = state_q;
        en_d       = en_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        step_d     = step_q;
        len_d      = len_q;
        loop_d     = loop_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d    = RUN;
                    len_d      = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
                    loop_d     = loop;
                    {en_d, wr_d, addr_d, hold_d} = rd_data;
                    step_d     = '0;
                    hold_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = '0;
                    step_d  = '0;
                    busy_d  = 1'b0;
                end else if (bus.ready) begin
                    if (hold_cnt_q != hold_q) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end else if (last && !loop_q) begin
                        state_d = FINISH;
                        en_d    = 1'b0;
                        wr_d    = 1'b0;
                        addr_d  = '0;
                        step_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        {en_d, wr_d, addr_d, hold_d} = rd_data;
                        step_d     = rd_idx;
                        hold_cnt_d = '0;
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            step_q     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            en_q       <= en_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            step_q     <= step_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.en   = en_q;
    assign bus.wr   = wr_q;
    assign bus.addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_q;

endmodule

// File: tb/tb_bus_stim_sequencer.sv
// Randomized self-checking bench for bus_stim_sequencer against a beat-queue model.
module tb_bus_stim_sequencer;
    import stim_pkg::*;

    localparam int ADDR_W  = 6;
    localparam int DEPTH   = 8;
    localparam int HOLD_W  = 4;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int LEN_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = entry_w(ADDR_W, HOLD_W);

    logic               clk = 1'b0;
    logic               rst;
    logic               prog_we;
    logic [IDX_W-1:0]   prog_idx;
    logic [ENTRY_W-1:0] prog_data;
    logic [LEN_W-1:0]   len;
    logic               loop;
    logic               start;
    logic               stop;
    logic               busy;
    logic               done;
    logic [IDX_W-1:0]   step_idx;

    bus_stim_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    bus_stim_sequencer #(
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH),
        .HOLD_W(HOLD_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .prog_we  (prog_we),
        .prog_idx (prog_idx),
        .prog_data(prog_data),
        .len      (len),
        .loop     (loop),
        .start    (start),
        .stop     (stop),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .step_idx (step_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              en;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        int                hold;
    } entry_t;

    entry_t tbl [DEPTH];
    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic program_entry(input int idx, input bit e, input bit w, input int a, input int h);
        logic [ADDR_W-1:0] a_v;
        logic [HOLD_W-1:0] h_v;
        a_v       = a[ADDR_W-1:0];
        h_v       = h[HOLD_W-1:0];
        prog_we   = 1'b1;
        prog_idx  = idx[IDX_W-1:0];
        prog_data = {e, w, a_v, h_v};
        tick();
        prog_we   = 1'b0;
        tbl[idx]  = '{en: e, wr: w, addr: a_v, hold: int'(h_v)};
    endtask

    task automatic program_random(input int n);
        for (int i = 0; i < n; i++)
            program_entry(i, 1'($urandom_range(1)), 1'($urandom_range(1)),
                          int'($urandom_range(63)), int'($urandom_range(3)));
    endtask

    // Model: the run is a flat list of beats; each accepted cycle consumes one.
    task automatic replay(input string name, input int len_in, input bit loop_in,
                          input int ready_pct, input int stop_entries);
        int eff;
        int n_entries;
        int e;
        bit rdy;
        int beat_idx [$];
        bit beat_last [$];
        eff       = (len_in > DEPTH) ? DEPTH : len_in;
        n_entries = loop_in ? stop_entries : eff;
        for (int i = 0; i < n_entries; i++) begin
            e = i % eff;
            for (int b = 0; b <= tbl[e].hold; b++) begin
                beat_idx.push_back(e);
                beat_last.push_back(b == tbl[e].hold);
            end
        end
        len       = len_in[LEN_W-1:0];
        loop      = loop_in;
        start     = 1'b1;
        stop      = 1'b0;
        bus.ready = 1'b1;
        tick();
        start = 1'b0;
        while (beat_idx.size() > 0) begin
            e = beat_idx[0];
            checks++;
            if ({bus.en, bus.wr, bus.addr, busy, done, step_idx} !==
                {tbl[e].en, tbl[e].wr, tbl[e].addr, 1'b1, 1'b0, IDX_W'(e)}) begin
                errors++;
                $display("FAIL %s beat: got en=%b wr=%b addr=%0d busy=%b done=%b step=%0d, want en=%b wr=%b addr=%0d busy=1 done=0 step=%0d",
                         name, bus.en, bus.wr, bus.addr, busy, done, step_idx,
                         tbl[e].en, tbl[e].wr, tbl[e].addr, e);
            end
            rdy       = ($urandom_range(99) < ready_pct);
            bus.ready = rdy;
            tick();
            if (rdy) begin
                void'(beat_idx.pop_front());
                void'(beat_last.pop_front());
            end
        end
        if (loop_in) begin
            e = stop_entries % eff;
            checks++;
            if ({bus.addr, step_idx, busy} !== {tbl[e].addr, IDX_W'(e), 1'b1}) begin
                errors++;
                $display("FAIL %s wrap: got addr=%0d step=%0d busy=%b, want addr=%0d step=%0d busy=1",
                         name, bus.addr, step_idx, busy, tbl[e].addr, e);
            end
            stop      = 1'b1;
            bus.ready = 1'($urandom_range(1));
            tick();
            stop = 1'b0;
            checks++;
            if ({bus.en, bus.wr, bus.addr, busy, done} !== {1'b0, 1'b0, 6'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s stop: got en=%b wr=%b addr=%0d busy=%b done=%b, want all 0",
                         name, bus.en, bus.wr, bus.addr, busy, done);
            end
        end else begin
            checks++;
            if ({bus.en, bus.wr, bus.addr, busy, done} !== {1'b0, 1'b0, 6'd0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL %s finish: got en=%b wr=%b addr=%0d busy=%b done=%b, want en=0 wr=0 addr=0 busy=0 done=1",
                         name, bus.en, bus.wr, bus.addr, busy, done);
            end
        end
        bus.ready = 1'b1;
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL %s idle_after: got done=%b busy=%b, want 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_we = 1'b0; prog_idx = '0; prog_data = '0; len = '0;
        loop = 1'b0; start = 1'b0; stop = 1'b0; bus.ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.en, bus.wr, bus.addr, busy, done, step_idx} !== '0) begin
            errors++;
            $display("FAIL reset: got en=%b wr=%b addr=%0d busy=%b done=%b step=%0d, want all 0",
                     bus.en, bus.wr, bus.addr, busy, done, step_idx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int exp_addr [5] = '{12, 14, 23, 48, 56};
        bit exp_en   [5] = '{1, 1, 1, 1, 0};
        bit exp_wr   [5] = '{1, 1, 0, 0, 0};
        for (int i = 0; i < 5; i++) program_entry(i, exp_en[i], exp_wr[i], exp_addr[i], 0);
        len = LEN_W'(5); loop = 1'b0; bus.ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.en, bus.wr, int'(bus.addr), busy} !== {exp_en[i], exp_wr[i], exp_addr[i], 1'b1}) begin
                errors++;
                $display("FAIL basic entry%0d: got en=%b wr=%b addr=%0d busy=%b, want en=%b wr=%b addr=%0d busy=1",
                         i, bus.en, bus.wr, bus.addr, busy, exp_en[i], exp_wr[i], exp_addr[i]);
            end
            tick();
        end
        checks++;
        if ({bus.en, busy, done} !== 3'b001) begin
            errors++;
            $display("FAIL basic done: got en=%b busy=%b done=%b, want 0 0 1", bus.en, busy, done);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL basic done_pulse: got done=%b, want 0", done);
        end
    endtask

    task automatic test_hold_stall();
        bit rdy_seq [6] = '{1, 0, 0, 1, 1, 1};
        int exp_addr [6] = '{5, 5, 5, 5, 5, 9};
        program_entry(0, 1, 1, 5, 2);
        program_entry(1, 1, 0, 9, 0);
        len = LEN_W'(2); loop = 1'b0; bus.ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({int'(bus.addr), bus.en, busy} !== {exp_addr[i], 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL hold_stall cycle%0d: got addr=%0d en=%b busy=%b, want addr=%0d en=1 busy=1",
                         i, bus.addr, bus.en, busy, exp_addr[i]);
            end
            bus.ready = rdy_seq[i];
            tick();
        end
        checks++;
        if ({bus.en, done} !== 2'b01) begin
            errors++;
            $display("FAIL hold_stall done: got en=%b done=%b, want 0 1", bus.en, done);
        end
        tick();
    endtask

    task automatic test_loop_stop();
        program_random(3);
        replay("loop_full", 3, 1'b1, 100, 10);
        replay("loop_stall", 3, 1'b1, 60, 10);
    endtask

    task automatic test_reset_mid_run();
        int n;
        program_random(5);
        len = LEN_W'(5); loop = 1'b0; bus.ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (step_idx !== IDX_W'(2) && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (step_idx !== IDX_W'(2)) begin
            errors++;
            $display("FAIL rst_mid wait: step_idx=%0d after %0d cycles, want 2", step_idx, n);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({bus.en, bus.wr, bus.addr, busy, done, step_idx} !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: got en=%b wr=%b addr=%0d busy=%b done=%b step=%0d, want all 0",
                     bus.en, bus.wr, bus.addr, busy, done, step_idx);
        end
        replay("rst_restart", 5, 1'b0, 100, 0);
    endtask

    task automatic test_corners();
        // start with len=0, then start together with stop
        for (int k = 0; k < 2; k++) begin
            len   = (k == 0) ? LEN_W'(0) : LEN_W'(3);
            stop  = (k == 1);
            start = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick();
                checks++;
                if ({bus.en, busy, done} !== 3'b000) begin
                    errors++;
                    $display("FAIL %s: got en=%b busy=%b done=%b, want 0 0 0",
                             (k == 0) ? "len0_start" : "start_stop", bus.en, busy, done);
                end
            end
            start = 1'b0;
            stop  = 1'b0;
        end
        // writes while running must not reach the table
        program_random(3);
        len = LEN_W'(3); loop = 1'b1; bus.ready = 1'b1; start = 1'b1;
        tick();
        start     = 1'b0;
        prog_we   = 1'b1;
        prog_idx  = '0;
        prog_data = {1'b1, 1'b1, ~tbl[0].addr, 4'd7};
        for (int i = 0; i < 3; i++) tick();
        prog_we = 1'b0;
        stop    = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        replay("prog_in_run", 3, 1'b0, 100, 0);
        // len beyond DEPTH clamps to DEPTH; includes the longest hold
        program_random(DEPTH);
        program_entry(DEPTH - 1, 1, 0, 33, 15);
        replay("len_clamp", DEPTH + 1, 1'b0, 80, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            program_random(DEPTH);
            replay("random", int'($urandom_range(DEPTH, 1)), 1'($urandom_range(1)),
                   int'($urandom_range(100, 50)), int'($urandom_range(12, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_loop_stop();
        test_reset_mid_run();
        test_corners();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
